// File: rtl/pixel_readout_if.sv
// Sample stream from the pixel reader to its downstream consumer.
// The reader drives data/index/valid; the consumer drives ready.
interface pixel_readout_if #(
    parameter int PIXEL_BITS = 8,
    parameter int IDX_W      = 2
);
    logic [PIXEL_BITS-1:0] out_data;
    logic [IDX_W-1:0]      out_index;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pixel_readout.sv
// Scans the shared tristate pixel bus one pixel at a time and queues
// {index, sample} pairs in a small FIFO drained over a valid/ready stream.
module pixel_readout #(
    parameter int PIXEL_BITS    = 8,
    parameter int NUM_PIXELS    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_read,
    output logic [NUM_PIXELS-1:0] read_sel,
    input  logic [PIXEL_BITS-1:0] pix_data,
    pixel_readout_if.master       stream,
    output logic                  busy,
    output logic                  done
);
    localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = IDX_W + PIXEL_BITS;
    localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];
    localparam logic [NUM_PIXELS-1:0] SEL_ONE = NUM_PIXELS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CAPTURE,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;

    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr, r_rd;
    logic [PTR_W:0]   r_count;

    logic w_sel_on, w_push, w_pop, w_full, w_empty;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && stream.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // With no settle time a pixel goes straight from GAP/IDLE to CAPTURE.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_sel_on   = 1'b0;
        w_push     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_read) begin
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = NO_SETTLE ? S_CAPTURE : S_SELECT;
                end
            end
            S_SELECT: begin
                w_sel_on = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_CAPTURE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                w_sel_on = 1'b1;
                if (!w_full) begin
                    w_push     = 1'b1;
                    w_state_nx = (r_idx == LAST_IDX) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                w_idx_nx   = r_idx + IDX_W'(1);
                w_state_nx = NO_SETTLE ? S_CAPTURE : S_SELECT;
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign read_sel = w_sel_on ? (SEL_ONE << r_idx) : '0;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {r_idx, pix_data};
    end

    // Full is judged on the start-of-cycle count, so a pop never frees
    // space for a push in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (PTR_W+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    assign stream.out_valid = !w_empty;
    assign stream.out_data  = r_mem[r_rd][PIXEL_BITS-1:0];
    assign stream.out_index = r_mem[r_rd][ENT_W-1:PIXEL_BITS];
endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: three configurations against a timeline/queue
// model, plus literal expectations for the documented scenarios.
module tb_pixel_readout;
    localparam int NI = 3;
    localparam int MS [NI] = '{1, 1, 0};
    localparam int MN [NI] = '{4, 4, 1};
    localparam int MD [NI] = '{8, 2, 2};

    logic clk;
    logic reset;
    logic start [NI];
    logic ready [NI];
    logic [7:0] pv [NI][4];
    logic [7:0] pdat [NI];
    logic [3:0] rsel [NI];
    logic [7:0] odat [NI];
    logic [1:0] oidx [NI];
    logic oval [NI];
    logic busy_w [NI];
    logic done_w [NI];

    logic [3:0] rs0, rs1;
    logic [0:0] rs2;

    pixel_readout_if #(.PIXEL_BITS(8), .IDX_W(2)) s0 ();
    pixel_readout_if #(.PIXEL_BITS(8), .IDX_W(2)) s1 ();
    pixel_readout_if #(.PIXEL_BITS(8), .IDX_W(1)) s2 ();

    pixel_readout #(
        .PIXEL_BITS(8), .NUM_PIXELS(4),
        .SETTLE_CYCLES(1), .FIFO_DEPTH(8)
    ) u0 (
        .clk(clk), .reset(reset), .start_read(start[0]),
        .read_sel(rs0), .pix_data(pdat[0]), .stream(s0.master),
        .busy(busy_w[0]), .done(done_w[0])
    );

    pixel_readout #(
        .PIXEL_BITS(8), .NUM_PIXELS(4),
        .SETTLE_CYCLES(1), .FIFO_DEPTH(2)
    ) u1 (
        .clk(clk), .reset(reset), .start_read(start[1]),
        .read_sel(rs1), .pix_data(pdat[1]), .stream(s1.master),
        .busy(busy_w[1]), .done(done_w[1])
    );

    pixel_readout #(
        .PIXEL_BITS(8), .NUM_PIXELS(1),
        .SETTLE_CYCLES(0), .FIFO_DEPTH(2)
    ) u2 (
        .clk(clk), .reset(reset), .start_read(start[2]),
        .read_sel(rs2), .pix_data(pdat[2]), .stream(s2.master),
        .busy(busy_w[2]), .done(done_w[2])
    );

    assign s0.out_ready = ready[0];
    assign s1.out_ready = ready[1];
    assign s2.out_ready = ready[2];
    assign rsel[0] = rs0;
    assign rsel[1] = rs1;
    assign rsel[2] = {3'b000, rs2};
    assign odat[0] = s0.out_data;
    assign odat[1] = s1.out_data;
    assign odat[2] = s2.out_data;
    assign oidx[0] = s0.out_index;
    assign oidx[1] = s1.out_index;
    assign oidx[2] = {1'b0, s2.out_index};
    assign oval[0] = s0.out_valid;
    assign oval[1] = s1.out_valid;
    assign oval[2] = s2.out_valid;

    // Each selected pixel drives its own value onto the bus.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            pdat[i] = 8'h00;
            for (int j = 0; j < 4; j++)
                if (rsel[i][j]) pdat[i] = pv[i][j];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: a scan is a timeline of NUM*(SETTLE+2) slots; slots 0..SETTLE
    // of a pixel have it selected, slot SETTLE is the capture, the last
    // slot is the gap (or done for the last pixel). Capture waits on a
    // full queue.
    bit         m_act [NI];
    int         m_k [NI];
    logic [9:0] mq [NI][$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NI; i++) begin
                m_act[i] = 1'b0;
                m_k[i] = 0;
                mq[i].delete();
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                int n0, o, p, per;
                bit pop, push;
                logic [9:0] smp;
                per = MS[i] + 2;
                n0 = mq[i].size();
                pop = ready[i] && (n0 > 0);
                push = 1'b0;
                smp = '0;
                if (!m_act[i]) begin
                    if (start[i]) begin
                        m_act[i] = 1'b1;
                        m_k[i] = 0;
                    end
                end else begin
                    o = m_k[i] % per;
                    p = m_k[i] / per;
                    if (o < MS[i]) begin
                        m_k[i]++;
                    end else if (o == MS[i]) begin
                        if (n0 < MD[i]) begin
                            push = 1'b1;
                            smp = {p[1:0], pv[i][p]};
                            m_k[i]++;
                        end
                    end else if (p == MN[i] - 1) begin
                        m_act[i] = 1'b0;
                    end else begin
                        m_k[i]++;
                    end
                end
                if (pop) void'(mq[i].pop_front());
                if (push) mq[i].push_back(smp);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int o, p, per;
            logic [3:0] e_rs;
            logic e_done;
            per = MS[i] + 2;
            o = m_k[i] % per;
            p = m_k[i] / per;
            e_rs = (m_act[i] && o <= MS[i]) ? (4'b0001 << p) : 4'b0000;
            e_done = m_act[i] && (o == MS[i] + 1) && (p == MN[i] - 1);
            chk($sformatf("read_sel%0d", i), 32'(rsel[i]), 32'(e_rs));
            chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_act[i]));
            chk($sformatf("done%0d", i), 32'(done_w[i]), 32'(e_done));
            chk($sformatf("out_valid%0d", i), 32'(oval[i]),
                32'(mq[i].size() > 0));
            if (mq[i].size() > 0)
                chk($sformatf("out_head%0d", i), 32'({oidx[i], odat[i]}),
                    32'(mq[i][0]));
        end
    end

    logic [9:0] acc [NI][$];
    int         ndone [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (oval[i] && ready[i]) acc[i].push_back({oidx[i], odat[i]});
            if (done_w[i]) ndone[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear(input int i);
        acc[i].delete();
        ndone[i] = 0;
    endtask

    task automatic set_pv(input int i, input logic [7:0] base);
        for (int j = 0; j < 4; j++) pv[i][j] = base + 8'(j);
    endtask

    task automatic chk_stream(input string nm, input int i, input int cnt,
                              input int npix, input logic [7:0] base);
        chk({nm, "_count"}, 32'(acc[i].size()), 32'(cnt));
        for (int k = 0; k < cnt && k < acc[i].size(); k++)
            chk($sformatf("%s_%0d", nm, k), 32'(acc[i][k]),
                32'({2'(k % npix), base + 8'(k % npix)}));
    endtask

    logic [3:0] lrs [13];
    logic       ldn [13];
    logic       lbs [13];

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            ready[i] = 1'b1;
            set_pv(i, 8'h00);
        end
        repeat (3) tick();
        chk("rst_read_sel", 32'(rsel[0]), 32'h0);
        chk("rst_valid", 32'(oval[0]), 32'h0);
        chk("rst_busy", 32'(busy_w[0]), 32'h0);
        chk("rst_done", 32'(done_w[0]), 32'h0);
        reset = 1'b0;
        tick();

        // Scenario 1: default timing, bus = 0x10+idx.
        set_pv(0, 8'h10);
        clear(0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int e = 0; e < 13; e++) begin
            lrs[e] = rsel[0];
            ldn[e] = done_w[0];
            lbs[e] = busy_w[0];
            tick();
        end
        chk("t1_sel_e0", 32'(lrs[0]), 32'h1);
        chk("t1_sel_e1", 32'(lrs[1]), 32'h1);
        chk("t1_sel_e2", 32'(lrs[2]), 32'h0);
        chk("t1_sel_e3", 32'(lrs[3]), 32'h2);
        chk("t1_sel_e7", 32'(lrs[7]), 32'h4);
        chk("t1_sel_e9", 32'(lrs[9]), 32'h8);
        chk("t1_sel_e10", 32'(lrs[10]), 32'h8);
        chk("t1_sel_e11", 32'(lrs[11]), 32'h0);
        chk("t1_done_e10", 32'(ldn[10]), 32'h0);
        chk("t1_done_e11", 32'(ldn[11]), 32'h1);
        chk("t1_busy_e12", 32'(lbs[12]), 32'h0);
        chk("t1_ndone", 32'(ndone[0]), 32'd1);
        chk_stream("t1_stream", 0, 4, 4, 8'h10);

        // Scenario 3: a second start while busy is ignored.
        set_pv(0, 8'h40);
        clear(0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (3) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (15) tick();
        chk("t3_ndone", 32'(ndone[0]), 32'd1);
        chk_stream("t3_stream", 0, 4, 4, 8'h40);

        // Scenario 2: depth-2 FIFO stalls the scan at pixel 2.
        set_pv(1, 8'h20);
        clear(1);
        ready[1] = 1'b0;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        repeat (20) tick();
        chk("t2_stall_sel", 32'(rsel[1]), 32'h4);
        chk("t2_stall_busy", 32'(busy_w[1]), 32'h1);
        chk("t2_stall_head", 32'({oidx[1], odat[1]}), 32'({2'd0, 8'h20}));
        ready[1] = 1'b1;
        repeat (20) tick();
        chk("t2_ndone", 32'(ndone[1]), 32'd1);
        chk_stream("t2_stream", 1, 4, 4, 8'h20);

        // Scenario 5: single pixel, no settle.
        pv[2][0] = 8'h5A;
        clear(2);
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        chk("t5_sel_e0", 32'(rsel[2]), 32'h1);
        chk("t5_done_e0", 32'(done_w[2]), 32'h0);
        tick();
        chk("t5_sel_e1", 32'(rsel[2]), 32'h0);
        chk("t5_done_e1", 32'(done_w[2]), 32'h1);
        chk("t5_head_e1", 32'({oidx[2], odat[2]}), 32'({2'd0, 8'h5A}));
        tick();
        chk("t5_busy_e2", 32'(busy_w[2]), 32'h0);
        repeat (3) tick();
        chk_stream("t5_stream", 2, 1, 1, 8'h5A);

        // Scenario 4: reset during SELECT of pixel 1, then a clean scan.
        set_pv(0, 8'h30);
        ready[0] = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (3) tick();
        chk("t4_pre_sel", 32'(rsel[0]), 32'h2);
        chk("t4_pre_valid", 32'(oval[0]), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_sel", 32'(rsel[0]), 32'h0);
        chk("t4_rst_valid", 32'(oval[0]), 32'h0);
        chk("t4_rst_busy", 32'(busy_w[0]), 32'h0);
        tick();
        reset = 1'b0;
        ready[0] = 1'b1;
        tick();
        clear(0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (16) tick();
        chk_stream("t4_stream", 0, 4, 4, 8'h30);

        // Scenario 6: three back-to-back scans, ready toggling.
        clear(0);
        ready[0] = 1'b0;
        start[0] = 1'b1;
        for (int c = 0; c < 200 && ndone[0] < 3; c++) begin
            for (int j = 0; j < 4; j++) pv[0][j] = 8'h60 + 8'(j);
            ready[0] = ~ready[0];
            tick();
        end
        start[0] = 1'b0;
        chk("t6_ndone", 32'(ndone[0]), 32'd3);
        ready[0] = 1'b1;
        repeat (20) tick();
        chk_stream("t6_stream", 0, 12, 4, 8'h60);

        // Random traffic on all three configurations.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                ready[i] = ($urandom_range(0, 2) != 0);
                for (int j = 0; j < 4; j++) pv[i][j] = 8'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
